// File: rtl/maze_input_conditioner.sv
// Button conditioner for the maze player: 2-flop synchronisers, per-button debouncers,
// press pulses, and a frame-rate update strobe with frame-aligned button levels.
module maze_input_conditioner #(
  parameter int DEB_CYCLES = 500000,
  parameter int UPD_DIV    = 833334
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       update,
  output logic [3:0] btn_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(UPD_DIV);
  localparam logic [CW-1:0] DEB_LAST     = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST    = TW'(UPD_DIV - 1);
  // Levels change on the edge where tick becomes UPD_DIV/2, half a frame from each update rise.
  localparam logic [TW-1:0] TICK_CAPTURE = TW'(UPD_DIV / 2 - 1);

  logic [3:0]         raw;
  logic [3:0]         sync1;
  logic [3:0]         sync2;
  logic [3:0]         stable;
  logic [3:0]         stable_d;
  logic [3:0]         stable_next;
  logic [3:0]         level;
  logic [3:0][CW-1:0] deb_cnt;
  logic [3:0][CW-1:0] deb_cnt_next;
  logic [TW-1:0]      tick;

  // Bit order {up, down, left, right} = [3:0] throughout.
  assign raw = {up_raw, down_raw, left_raw, right_raw};
  assign {up, down, left, right} = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      // NOTE: non-blocking assignments so sync2 takes the previous sync1, forming a real 2-stage chain.
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise latches are inferred.
    stable_next  = stable;
    deb_cnt_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2[i] != stable[i]) begin
        if (deb_cnt[i] == DEB_LAST) stable_next[i] = sync2[i];
        else deb_cnt_next[i] = deb_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable    <= '1;
      stable_d  <= '1;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
      deb_cnt   <= '0;
      btn_press <= '0;
    end else begin
      stable    <= stable_next;
      stable_d  <= stable;
      deb_cnt   <= deb_cnt_next;
      btn_press <= stable_d & ~stable;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick   <= '0;
      update <= 1'b0;
      level  <= '1;
    end else begin
      tick   <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
      update <= (tick == TICK_LAST);
      if (tick == TICK_CAPTURE) level <= stable;
    end
  end

endmodule

// File: tb/tb_maze_input_conditioner.sv
// Directed bench for maze_input_conditioner with DEB_CYCLES=4, UPD_DIV=8;
// edges are counted from reset release.
module tb_maze_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up_raw = 1'b1, down_raw = 1'b1, left_raw = 1'b1, right_raw = 1'b1;
  logic       up, down, left, right, update;
  logic [3:0] btn_press;

  int n_cmp = 0;
  int n_err = 0;
  int ec    = 0;

  maze_input_conditioner #(.DEB_CYCLES(4), .UPD_DIV(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_raw    (up_raw),
    .down_raw  (down_raw),
    .left_raw  (left_raw),
    .right_raw (right_raw),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .update    (update),
    .btn_press (btn_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;     // edge after which outputs are compared
    logic [3:0] raw;    // raw buttons driven in the interval leading up to that edge
    logic [3:0] lvl;    // expected {up,down,left,right}
    logic       upd;
    logic [3:0] press;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(int at, logic [3:0] raw, logic [3:0] lvl, logic upd, logic [3:0] press);
    vec_t v;
    v.at = at; v.raw = raw; v.lvl = lvl; v.upd = upd; v.press = press;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r);
    {up_raw, down_raw, left_raw, right_raw} = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl, input logic upd, input logic [3:0] press);
    check({tag, " level"},  {4'h0, up, down, left, right}, {4'h0, lvl});
    check({tag, " update"}, {7'h0, update}, {7'h0, upd});
    check({tag, " press"},  {4'h0, btn_press}, {4'h0, press});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenarios 1, 2, 4, 5: reset, clean up press, release, simultaneous left+right.
    vecs.push_back(row( 1, 4'hF, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row( 7, 4'hF, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row( 8, 4'hF, 4'hF, 1'b1, 4'h0));
    vecs.push_back(row( 9, 4'hF, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(15, 4'h7, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(16, 4'h7, 4'hF, 1'b1, 4'h8));
    vecs.push_back(row(17, 4'h7, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(19, 4'h7, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(20, 4'h7, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(23, 4'h7, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(24, 4'h7, 4'h7, 1'b1, 4'h0));
    vecs.push_back(row(25, 4'h7, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(26, 4'hF, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(31, 4'hF, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(32, 4'hF, 4'h7, 1'b1, 4'h0));
    vecs.push_back(row(35, 4'hF, 4'h7, 1'b0, 4'h0));
    vecs.push_back(row(36, 4'hF, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(40, 4'hF, 4'hF, 1'b1, 4'h0));
    vecs.push_back(row(46, 4'hC, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(47, 4'hC, 4'hF, 1'b0, 4'h3));
    vecs.push_back(row(48, 4'hC, 4'hF, 1'b1, 4'h0));
    vecs.push_back(row(51, 4'hC, 4'hF, 1'b0, 4'h0));
    vecs.push_back(row(52, 4'hC, 4'hC, 1'b0, 4'h0));
    vecs.push_back(row(56, 4'hC, 4'hC, 1'b1, 4'h0));

    drive(4'hF);
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset", 4'hF, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    ec  = 0;

    foreach (vecs[k]) begin
      drive(vecs[k].raw);
      while (ec < vecs[k].at) step();
      check_all($sformatf("edge%0d", vecs[k].at), vecs[k].lvl, vecs[k].upd, vecs[k].press);
    end

    // Asynchronous reset while update is high and left/right are low: no clock edge needed.
    rst = 1'b0;
    drive(4'hF);
    #2;
    check_all("async_rst", 4'hF, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    ec  = 0;

    // Reset at tick==6 with down mid-debounce (counter at 2).
    step();
    step();
    drive(4'hB);
    repeat (4) step();
    rst = 1'b0;
    drive(4'hF);
    #2;
    check_all("rst_mid_deb", 4'hF, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    ec  = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_all($sformatf("post_rst%0d", e), 4'hF, (e == 8), 4'h0);
    end

    // Bouncing up: 3 cycles low, 1 high, never long enough to be accepted.
    for (int c = 0; c < 40; c++) begin
      drive((c % 4 == 3) ? 4'hF : 4'h7);
      step();
      check($sformatf("bounce%0d level", c), {4'h0, up, down, left, right}, 8'h0F);
      check($sformatf("bounce%0d press", c), {4'h0, btn_press}, 8'h00);
    end
    drive(4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maze_input_conditioner.md
Name: maze_input_conditioner

Overview:
Upstream stage of the maze player block. It synchronises and debounces the four raw active-low direction buttons and generates the frame-rate `update` strobe. The player block samples the button levels on the rising edge of `update`. The block guarantees the button outputs never change on the same clock edge that `update` rises.

Parameters:
DEB_CYCLES, 500000, consecutive clk cycles a synchronised input must differ from its stable value before it is accepted (10 ms at 50 MHz); minimum 1
UPD_DIV, 833334, clk cycles per `update` period (~60 Hz at 50 MHz); even, minimum 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
up_raw  in  1  raw up button, active-low, asynchronous to clk
down_raw  in  1  raw down button, active-low
left_raw  in  1  raw left button, active-low
right_raw  in  1  raw right button, active-low
up  out  1  debounced, frame-aligned up level, active-low
down  out  1  debounced, frame-aligned down level, active-low
left  out  1  debounced, frame-aligned left level, active-low
right  out  1  debounced, frame-aligned right level, active-low
update  out  1  one-clk-wide registered strobe, one per UPD_DIV cycles
btn_press  out  4  one-clk pulse on each debounced press; bit order {up,down,left,right} = [3:0]

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - All flops clear immediately.
  - Synchroniser and stable registers = 1 (released); debounce counters = 0.
  - up/down/left/right = 1; update = 0; btn_press = 0; tick counter = 0.
  - Reset asserted mid-debounce or mid-period discards all progress.
- Synchroniser: two flops per button, reset value 1.
- Debouncer (identical per button):
  - Counter width is $clog2(DEB_CYCLES+1).
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEB_CYCLES-1: stable <= sync2, counter <= 0.
  - sync2 != stable otherwise: counter <= counter+1.
  - Any bounce back to the stable value resets the counter.
  - Latency: for a clean change on a raw input, stable changes on the (DEB_CYCLES+2)th rising edge. Edge 1 is the first edge that captures the new raw value.
- btn_press[i]:
  - Registered; high for exactly one cycle, on the edge after stable[i] goes 1->0.
  - No pulse on release.
  - Several bits may assert together.
- Tick counter:
  - 0..UPD_DIV-1; increments every cycle; wraps UPD_DIV-1 -> 0.
  - update <= (tick == UPD_DIV-1).
  - First update high after the UPD_DIV-th edge following reset release. Then exactly every UPD_DIV cycles, width exactly 1 cycle.
  - Glitch-free (direct flop output), because the downstream block uses it as an edge.
- Frame alignment: up/down/left/right <= stable values only on the edge where tick == UPD_DIV/2. At all other times they hold.
  - Outputs are therefore stable for UPD_DIV/2 cycles on each side of every update rise.
  - A debounced change waits up to UPD_DIV cycles to appear.
- Simultaneous events:
  - Buttons are independent; no priority or opposite-direction lockout here (the player FSM owns priority).
  - A stable change coinciding with the capture edge captures the pre-change stable value; the new value appears at the next capture edge.
- Arithmetic: counters are unsigned. The tick counter never exceeds UPD_DIV-1. The debounce counter never exceeds DEB_CYCLES-1.

Test Plan (DEB_CYCLES=4, UPD_DIV=8, edges counted from reset release):

1. Reset hold then release, no buttons:
   - All outputs 1, btn_press=0.
   - update high only after edges 8, 16, 24, each for one cycle.
2. up_raw driven low at edge 10 and held:
   - Internal stable for up falls after edge 15 (10 + DEB_CYCLES + 2 - 1).
   - btn_press=4'b1000 for one cycle after edge 16.
   - up falls after edge 20 (tick==4 capture); update rises after edge 24 with up=0.
3. up_raw toggled low 3 cycles / high 1 cycle repeatedly for 40 cycles:
   - up stays 1; btn_press stays 0.
4. From scenario 2, up_raw returned high and held:
   - up returns to 1 at the first tick==4 capture at least 6 edges after the release; btn_press stays 0.
5. left_raw and right_raw driven low on the same edge:
   - btn_press=4'b0011 for one cycle.
   - left and right fall together on the same capture edge.
6. rst pulsed low mid-debounce and at tick==6:
   - All outputs return to reset values without a clock edge.
   - After release, the first update again comes after the 8th edge; the partial debounce yields no press.
